// File: rtl/fwd_mux_stage.sv
// N-input select stage with a registered valid/ready output and a 2-entry skid buffer.
// in_ready comes from a register, so no combinational path exists from out_ready to in_ready.
//
// state | meaning
// EMPTY | no entry held; out_valid = 0
// ONE   | output register holds the oldest entry
// FULL  | output register plus skid register both hold entries; in_ready = 0
module fwd_mux_stage #(
  parameter int BIT_WIDTH  = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_INPUTS*BIT_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]            sel,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            flush,
  output logic [BIT_WIDTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]            out_sel,
  output logic                            out_err,
  output logic                            out_valid,
  input  logic                            out_ready
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > 16 || SEL_WIDTH < $clog2(NUM_INPUTS)) begin : g_bad_param
    $error("fwd_mux_stage: NUM_INPUTS must be 2..16 and SEL_WIDTH >= clog2(NUM_INPUTS)");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [BIT_WIDTH-1:0]   mux_data;
  logic                   mux_err;
  logic [BIT_WIDTH-1:0]   sr_data;
  logic [SEL_WIDTH-1:0]   sr_sel;
  logic                   sr_err;
  logic                   in_xfer, out_xfer;
  logic                   load_or_in, load_or_sr, load_sr;

  // Out-of-range selects yield zero data, so unselected inputs never leak into the registers.
  always_comb begin
    mux_data = '0;
    mux_err  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        mux_data = in_data[k*BIT_WIDTH +: BIT_WIDTH];
        mux_err  = 1'b0;
      end
    end
  end

  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_nxt  = state;
    load_or_in = 1'b0;
    load_or_sr = 1'b0;
    load_sr    = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt  = ONE;
            load_or_in = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_or_in = 1'b1;
          end else if (in_xfer) begin
            state_nxt = FULL;
            load_sr   = 1'b1;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_nxt  = ONE;
            load_or_sr = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      out_sel  <= '0;
      out_err  <= 1'b0;
    end else if (load_or_in) begin
      out_data <= mux_data;
      out_sel  <= sel;
      out_err  <= mux_err;
    end else if (load_or_sr) begin
      out_data <= sr_data;
      out_sel  <= sr_sel;
      out_err  <= sr_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_data <= '0;
      sr_sel  <= '0;
      sr_err  <= 1'b0;
    end else if (load_sr) begin
      sr_data <= mux_data;
      sr_sel  <= sel;
      sr_err  <= mux_err;
    end
  end

endmodule

// File: tb/tb_fwd_mux_stage.sv
// Bench for fwd_mux_stage: directed steps on a 5-input instance, random traffic on a 16-input one.
// A negedge scoreboard tracks both instances; directed steps add explicit value checks.
module tb_fwd_mux_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [159:0] ind_a;
  logic [2:0]   sel_a, os_a;
  logic         iv_a, ir_a, fl_a, ov_a, ordy_a, oe_a;
  logic [31:0]  od_a;

  logic [511:0] ind_b;
  logic [4:0]   sel_b, os_b;
  logic         iv_b, ir_b, fl_b, ov_b, ordy_b, oe_b;
  logic [31:0]  od_b;

  fwd_mux_stage #(.BIT_WIDTH(32), .NUM_INPUTS(5), .SEL_WIDTH(3)) dut_a (
    .clk(clk), .rst(rst), .in_data(ind_a), .sel(sel_a), .in_valid(iv_a), .in_ready(ir_a),
    .flush(fl_a), .out_data(od_a), .out_sel(os_a), .out_err(oe_a), .out_valid(ov_a),
    .out_ready(ordy_a));

  fwd_mux_stage #(.BIT_WIDTH(32), .NUM_INPUTS(16), .SEL_WIDTH(5)) dut_b (
    .clk(clk), .rst(rst), .in_data(ind_b), .sel(sel_b), .in_valid(iv_b), .in_ready(ir_b),
    .flush(fl_b), .out_data(od_b), .out_sel(os_b), .out_err(oe_b), .out_valid(ov_b),
    .out_ready(ordy_b));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  s;
    logic        e;
  } ent_t;

  ent_t sbq [2][$];
  int   cnt [2];
  logic exp_rdy [2];
  logic hv [2];
  ent_t held [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int id, input int n, input logic iv, input logic ir, input logic fl,
                     input logic ov, input logic ordy, input logic [31:0] od, input logic [7:0] os,
                     input logic oe, input logic [511:0] ind, input logic [7:0] isel);
    ent_t e;
    ent_t x;
    logic in_x, out_x;
    int   nxt;
    if (!rst) begin
      sbq[id].delete();
      cnt[id]     = 0;
      exp_rdy[id] = 1'b1;
      hv[id]      = 1'b0;
      return;
    end
    chk($sformatf("dut%0d out_valid", id), 64'(ov), 64'(cnt[id] != 0));
    chk($sformatf("dut%0d in_ready", id), 64'(ir), 64'(exp_rdy[id]));
    if (hv[id]) chk($sformatf("dut%0d hold", id), 64'({od, os, oe}), 64'(held[id]));
    out_x = (cnt[id] != 0) && ordy;
    in_x  = iv && exp_rdy[id];
    if (out_x && sbq[id].size() != 0) begin
      x = sbq[id].pop_front();
      chk($sformatf("dut%0d out_data", id), 64'(od), 64'(x.d));
      chk($sformatf("dut%0d out_sel", id), 64'(os), 64'(x.s));
      chk($sformatf("dut%0d out_err", id), 64'(oe), 64'(x.e));
    end
    if (fl) begin
      sbq[id].delete();
      nxt = 0;
    end else begin
      if (in_x) begin
        e.s = isel;
        e.e = (int'(isel) >= n);
        e.d = e.e ? 32'h0 : ind[int'(isel)*32 +: 32];
        sbq[id].push_back(e);
      end
      nxt = cnt[id] + int'(in_x) - int'(out_x);
    end
    hv[id]      = (cnt[id] != 0) && !ordy && !fl;
    held[id]    = {od, os, oe};
    cnt[id]     = nxt;
    exp_rdy[id] = (nxt != 2);
  endtask

  always @(negedge clk) begin
    mon(0, 5, iv_a, ir_a, fl_a, ov_a, ordy_a, od_a, 8'(os_a), oe_a, 512'(ind_a), 8'(sel_a));
    mon(1, 16, iv_b, ir_b, fl_b, ov_b, ordy_b, od_b, 8'(os_b), oe_b, ind_b, 8'(sel_b));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int k, input logic [31:0] v);
    ind_a[k*32 +: 32] = v;
  endtask

  initial begin
    rst = 1'b0;
    ind_a = '0; sel_a = '0; iv_a = 1'b0; fl_a = 1'b0; ordy_a = 1'b0;
    ind_b = '0; sel_b = '0; iv_b = 1'b0; fl_b = 1'b0; ordy_b = 1'b0;
    tick();
    tick();
    chk("reset out_valid", 64'(ov_a), 64'(0));
    chk("reset out_data", 64'(od_a), 64'(0));
    chk("reset in_ready", 64'(ir_a), 64'(1));
    rst = 1'b1;
    tick();

    // pass-through with sel = 0..3
    for (int k = 0; k < 5; k++) set_a(k, 32'h1000_0000 + 32'(k));
    ordy_a = 1'b1;
    iv_a   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel_a = 3'(k);
      tick();
      chk($sformatf("pass data %0d", k), 64'(od_a), 64'(32'h1000_0000 + 32'(k)));
      chk($sformatf("pass valid %0d", k), 64'(ov_a), 64'(1));
      chk($sformatf("pass ready %0d", k), 64'(ir_a), 64'(1));
    end
    iv_a = 1'b0;
    tick();
    chk("pass drained", 64'(ov_a), 64'(0));

    // backpressure: A, B, C offered while out_ready is low for three edges
    set_a(0, 32'hAAAA_0001);
    set_a(1, 32'hBBBB_0002);
    set_a(2, 32'hCCCC_0003);
    ordy_a = 1'b0;
    iv_a   = 1'b1;
    sel_a  = 3'd0;
    tick();
    chk("bp A out", 64'(od_a), 64'(32'hAAAA_0001));
    chk("bp ready1", 64'(ir_a), 64'(1));
    sel_a = 3'd1;
    tick();
    chk("bp ready2", 64'(ir_a), 64'(0));
    chk("bp A held", 64'(od_a), 64'(32'hAAAA_0001));
    sel_a = 3'd2;
    tick();
    chk("bp ready3", 64'(ir_a), 64'(0));
    chk("bp A held3", 64'(od_a), 64'(32'hAAAA_0001));
    ordy_a = 1'b1;
    tick();
    chk("bp B out", 64'(od_a), 64'(32'hBBBB_0002));
    chk("bp ready4", 64'(ir_a), 64'(1));
    tick();
    chk("bp C out", 64'(od_a), 64'(32'hCCCC_0003));
    iv_a = 1'b0;
    tick();
    chk("bp drained", 64'(ov_a), 64'(0));

    // out-of-range select
    ind_a = '1;
    iv_a  = 1'b1;
    sel_a = 3'd6;
    tick();
    chk("oor data", 64'(od_a), 64'(0));
    chk("oor sel", 64'(os_a), 64'(6));
    chk("oor err", 64'(oe_a), 64'(1));
    sel_a = 3'd4;
    tick();
    chk("in4 data", 64'(od_a), 64'(32'hFFFF_FFFF));
    chk("in4 err", 64'(oe_a), 64'(0));
    sel_a = 3'd5;
    tick();
    chk("sel5 err", 64'(oe_a), 64'(1));
    chk("sel5 data", 64'(od_a), 64'(0));
    iv_a = 1'b0;
    tick();

    // flush while FULL with a concurrent input offer
    for (int k = 0; k < 5; k++) set_a(k, 32'hF100_0000 + 32'(k));
    ordy_a = 1'b0;
    iv_a   = 1'b1;
    sel_a  = 3'd0;
    tick();
    sel_a = 3'd1;
    tick();
    chk("flush full", 64'(ir_a), 64'(0));
    sel_a = 3'd2;
    fl_a  = 1'b1;
    tick();
    chk("flush valid", 64'(ov_a), 64'(0));
    chk("flush ready", 64'(ir_a), 64'(1));
    fl_a   = 1'b0;
    iv_a   = 1'b0;
    ordy_a = 1'b1;
    tick();
    chk("flush stays empty", 64'(ov_a), 64'(0));
    tick();

    // asynchronous reset mid-burst
    for (int k = 0; k < 5; k++) set_a(k, 32'h7700_0000 + 32'(k));
    iv_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel_a = 3'(k + 1);
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    chk("arst valid", 64'(ov_a), 64'(0));
    chk("arst data", 64'(od_a), 64'(0));
    chk("arst sel", 64'(os_a), 64'(0));
    chk("arst err", 64'(oe_a), 64'(0));
    chk("arst ready", 64'(ir_a), 64'(1));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_a(2, 32'h5EED_0002);
    sel_a = 3'd2;
    tick();
    chk("post-reset data", 64'(od_a), 64'(32'h5EED_0002));
    chk("post-reset valid", 64'(ov_a), 64'(1));
    iv_a = 1'b0;
    tick();
    tick();

    // random traffic on the 16-input instance
    for (int i = 0; i < 10000; i++) begin
      for (int w = 0; w < 16; w++) ind_b[w*32 +: 32] = $urandom;
      sel_b  = 5'($urandom_range(0, 19));
      iv_b   = ($urandom_range(0, 3) != 0);
      ordy_b = ($urandom_range(0, 2) != 0);
      fl_b   = ($urandom_range(0, 63) == 0);
      tick();
    end
    iv_b   = 1'b0;
    fl_b   = 1'b0;
    ordy_b = 1'b1;
    tick();
    tick();
    tick();
    chk("random drained", 64'(ov_b), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
